// File: rtl/display_pkg.sv
// Shared types and helpers for the 8-digit BCD display scan path.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_word_t;

  function automatic logic is_bcd(bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

  function automatic logic word_is_bcd(bcd_word_t w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ok = ok & is_bcd(w[i]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled clocks; holds while en=0.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] presc_q, presc_d;

  assign tick = en && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scanner for the 8-digit BCD display: double-buffered word, digit select,
// leading-zero blanking and sticky invalid-digit flag.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  output logic             load_ready,
  output logic [SEL_W-1:0] sel,
  output logic [3:0]       bcd_out,
  output logic             blank,
  output logic             frame_done,
  output logic             bcd_err
);

  // Handshake: a word transfers on any rising edge where load_valid & load_ready;
  // load_ready depends only on registered state, never on load_valid.

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  logic             tick;
  logic             accept;
  logic             wrap;
  bcd_word_t        load_word;

  logic [SEL_W-1:0] sel_q, sel_d;
  bcd_word_t        active_q, active_d;
  bcd_word_t        shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             ready_q;
  logic             frame_done_q;
  logic             bcd_err_q, bcd_err_d;
  logic             first_q;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  lz_hit;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign load_word = load_data;
  assign accept    = load_valid & ready_q;
  assign wrap      = tick & (sel_q == LAST_SEL);

  always_comb begin
    sel_d     = sel_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    bcd_err_d = bcd_err_q;
    if (tick) begin
      sel_d = sel_q + 1'b1;
    end
    // A wrap with a pending word and an accept are mutually exclusive (ready=0).
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = load_word;
      pending_d = 1'b1;
      if (!word_is_bcd(load_word)) begin
        bcd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      bcd_err_q    <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      sel_q        <= sel_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      ready_q      <= ~pending_d;
      frame_done_q <= wrap;
      bcd_err_q    <= bcd_err_d;
      first_q      <= 1'b0;
    end
  end

  // upper_zero[i] = digits NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (active_q[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] & (active_q[i] == 4'd0);
    end
  end

  assign lz_hit     = LZ_BLANK && (sel_q != '0) && upper_zero[sel_q];
  assign bcd_out    = active_q[sel_q];
  assign blank      = first_q | ~en | ~is_bcd(bcd_out) | lz_hit;
  assign frame_done = frame_done_q & en;
  assign load_ready = ready_q;
  assign sel        = sel_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4, leading-zero blanking on.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [2:0]  sel;
  logic [3:0]  bcd_out;
  logic        blank;
  logic        frame_done;
  logic        bcd_err;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(.PRESCALE(4), .LZ_BLANK(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .sel        (sel),
    .bcd_out    (bcd_out),
    .blank      (blank),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until frame_done is seen, at most 40 cycles; leaves the bench just after the wrap edge.
  task automatic wait_wrap(input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    chk({tag, "_wrap_seen"}, frame_done, 1'b1);
  endtask

  initial begin
    int pulses;
    rst_n      = 1'b0;
    en         = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset values
    step(2);
    chk("rst_sel", sel, 3'd0);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_err", bcd_err, 1'b0);
    chk("rst_blank", blank, 1'b1);

    // 1: free-running scan of an all-zero word
    rst_n = 1'b1;
    step(1);
    chk("t1_sel0", sel, 3'd0);
    chk("t1_bcd0", bcd_out, 4'd0);
    chk("t1_blank0", blank, 1'b0);
    step(3);
    for (int s = 1; s < 8; s++) begin
      chk("t1_sel", sel, s);
      chk("t1_bcd", bcd_out, 4'd0);
      chk("t1_blank_lz", blank, 1'b1);
      chk("t1_fd_low", frame_done, 1'b0);
      step(4);
    end
    chk("t1_wrap_sel", sel, 3'd0);
    chk("t1_wrap_fd", frame_done, 1'b1);
    step(1);
    chk("t1_fd_one_cycle", frame_done, 1'b0);
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (frame_done === 1'b1) pulses++;
    end
    chk("t1_fd_per_frame", pulses, 1);

    // 2: load 0x00001234 mid-frame
    wait_wrap("t2_sync");
    step(10);
    chk("t2_mid_sel", sel, 3'd2);
    load_valid = 1'b1;
    load_data  = 32'h0000_1234;
    step(1);
    load_valid = 1'b0;
    load_data  = 32'hFFFF_FFFF;
    chk("t2_ready_fall", load_ready, 1'b0);
    chk("t2_old_digit", bcd_out, 4'd0);
    wait_wrap("t2");
    chk("t2_ready_rise", load_ready, 1'b1);
    for (int s = 0; s < 8; s++) begin
      chk("t2_sel", sel, s);
      if (s < 4) begin
        chk("t2_digit", bcd_out, 4 - s);
        chk("t2_shown", blank, 1'b0);
      end else begin
        chk("t2_lz", blank, 1'b1);
      end
      step(4);
    end
    chk("t2_next_wrap", frame_done, 1'b1);

    // 3: second offer while pending is held off until ready returns
    load_valid = 1'b1;
    load_data  = 32'h0000_5678;
    step(1);
    chk("t3_a_taken", load_ready, 1'b0);
    load_data = 32'h0000_0987;
    step(3);
    chk("t3_b_held_off", load_ready, 1'b0);
    wait_wrap("t3_a");
    chk("t3_a_shown", bcd_out, 4'd8);
    chk("t3_ready_back", load_ready, 1'b1);
    step(1);
    load_valid = 1'b0;
    chk("t3_b_taken", load_ready, 1'b0);
    chk("t3_a_still", bcd_out, 4'd8);
    wait_wrap("t3_b");
    chk("t3_b_d0", bcd_out, 4'd7);
    step(4);
    chk("t3_b_d1", bcd_out, 4'd8);
    step(4);
    chk("t3_b_d2", bcd_out, 4'd9);
    step(4);
    chk("t3_b_d3_blank", blank, 1'b1);

    // 4: invalid digit sets the sticky error
    chk("t4_err_before", bcd_err, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h0000_A005;
    step(1);
    load_valid = 1'b0;
    chk("t4_err_set", bcd_err, 1'b1);
    wait_wrap("t4");
    chk("t4_d0", bcd_out, 4'd5);
    chk("t4_d0_shown", blank, 1'b0);
    step(4);
    chk("t4_d1_zero_shown", blank, 1'b0);
    step(4);
    chk("t4_d2_val", bcd_out, 4'd0);
    chk("t4_d2_shown", blank, 1'b0);
    step(4);
    chk("t4_d3_val", bcd_out, 4'hA);
    chk("t4_d3_blank", blank, 1'b1);
    step(4);
    chk("t4_d4_lz", blank, 1'b1);
    wait_wrap("t4_end");
    chk("t4_err_sticky", bcd_err, 1'b1);

    // 5: accept lands on the wrap edge itself
    step(31);
    chk("t5_pre_sel", sel, 3'd7);
    load_valid = 1'b1;
    load_data  = 32'h0000_0042;
    step(1);
    load_valid = 1'b0;
    chk("t5_wrap_fd", frame_done, 1'b1);
    chk("t5_old_d0", bcd_out, 4'd5);
    chk("t5_ready", load_ready, 1'b0);
    step(4);
    chk("t5_old_d1", bcd_out, 4'd0);
    wait_wrap("t5");
    chk("t5_new_d0", bcd_out, 4'd2);
    chk("t5_ready_back", load_ready, 1'b1);
    step(4);
    chk("t5_new_d1", bcd_out, 4'd4);
    chk("t5_new_d1_shown", blank, 1'b0);
    step(4);
    chk("t5_new_d2_lz", blank, 1'b1);

    // 6: en=0 for 10 clocks mid-slot, then reset with a pending word
    step(2);
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t6_frozen_sel", sel, 3'd2);
      chk("t6_off_blank", blank, 1'b1);
      if (frame_done === 1'b1) pulses++;
    end
    chk("t6_no_fd", pulses, 0);
    en = 1'b1;
    step(1);
    chk("t6_resume_sel2", sel, 3'd2);
    step(1);
    chk("t6_resume_sel3", sel, 3'd3);
    load_valid = 1'b1;
    load_data  = 32'h0000_0777;
    step(1);
    load_valid = 1'b0;
    chk("t6_pending", load_ready, 1'b0);
    step(5);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_sel", sel, 3'd0);
    chk("t6_rst_ready", load_ready, 1'b1);
    chk("t6_rst_err", bcd_err, 1'b0);
    chk("t6_rst_blank", blank, 1'b1);
    rst_n = 1'b1;
    step(1);
    chk("t6_active_zero", bcd_out, 4'd0);
    chk("t6_zero_shown", blank, 1'b0);
    wait_wrap("t6");
    chk("t6_discarded", bcd_out, 4'd0);
    chk("t6_ready_after", load_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
